mmio_bridge: RTL and testbench

Memory-mapped I/O bridge between the processor's data-memory port and the data RAM. It decodes the processor's 32-bit `address_dmem` and forwards RAM-range accesses unchanged. It serves a small register window of board I/O: LED output register, synchronized and debounced switch input, switch-change flag, and free-running cycle counter. Read data is returned with the same one-cycle latency as the RAM, so `processor` needs no changes.

---
 rtl/mmio_defs.sv | 23 ++
 rtl/sw_debounce.sv | 52 +++++
 rtl/mmio_bridge.sv | 105 ++++++++++
 tb/tb_mmio_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_defs.sv
// Shared address map and helpers for the MMIO bridge and any future peripherals.
package mmio_defs;

  localparam logic [31:0] ADDR_LED   = 32'h0000_1000;
  localparam logic [31:0] ADDR_SW    = 32'h0000_1001;
  localparam logic [31:0] ADDR_CYCLE = 32'h0000_1002;
  localparam logic [31:0] ADDR_SWCHG = 32'h0000_1003;

  // Any set bit under this mask moves the access out of the RAM range.
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_F000;

  localparam int SW_W = 16;

  typedef enum logic {
    SEL_RAM    = 1'b0,
    SEL_PERIPH = 1'b1
  } rd_sel_t;

  function automatic logic is_ram_addr(input logic [31:0] addr);
    return (addr & RAM_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus debouncer for the board switches; emits a
// one-cycle upd pulse whenever the accepted switch vector changes.
module sw_debounce
  import mmio_defs::*;
#(
  parameter int DB_COUNT = 100000,
  parameter int DB_W     = 17
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] sw_stable,
  output logic            upd
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_COUNT - 1);

  logic [SW_W-1:0] sync1_reg;
  logic [SW_W-1:0] sw_s_reg;
  logic [SW_W-1:0] stable_reg;
  logic [DB_W-1:0] cnt_reg;
  logic            upd_reg;

  // The counter restarts on the edge where sw_s takes a new value, so a
  // change reaches sw_stable exactly 2 + DB_COUNT edges after it hits SW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg  <= '0;
      sw_s_reg   <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
      upd_reg    <= 1'b0;
    end else begin
      sync1_reg <= sw;
      sw_s_reg  <= sync1_reg;
      upd_reg   <= 1'b0;
      if (sync1_reg != sw_s_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((cnt_reg == CNT_MAX) && (sw_s_reg != stable_reg)) begin
        stable_reg <= sw_s_reg;
        upd_reg    <= 1'b1;
      end
    end
  end

  assign sw_stable = stable_reg;
  assign upd       = upd_reg;

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory bridge: forwards RAM-range accesses and serves the LED, switch,
// switch-change and cycle-counter registers with the RAM's one-cycle read latency.
module mmio_bridge
  import mmio_defs::*;
#(
  parameter int DB_COUNT = 100000,
  parameter int DB_W     = 17
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wren,
  input  logic [31:0]     address_dmem,
  input  logic [31:0]     data,
  output logic [31:0]     q_dmem,
  output logic            ram_wEn,
  output logic [11:0]     ram_addr,
  output logic [31:0]     ram_dataIn,
  input  logic [31:0]     ram_dataOut,
  input  logic [SW_W-1:0] SW,
  output logic [15:0]     LED
);

  logic [SW_W-1:0] sw_stable;
  logic            upd;

  sw_debounce #(
    .DB_COUNT (DB_COUNT),
    .DB_W     (DB_W)
  ) u_sw_debounce (
    .clock     (clock),
    .reset     (reset),
    .sw        (SW),
    .sw_stable (sw_stable),
    .upd       (upd)
  );

  logic hit_ram;
  logic hit_led;
  logic hit_cycle;
  logic hit_swchg;

  assign hit_ram   = is_ram_addr(address_dmem);
  assign hit_led   = (address_dmem == ADDR_LED);
  assign hit_cycle = (address_dmem == ADDR_CYCLE);
  assign hit_swchg = (address_dmem == ADDR_SWCHG);

  assign ram_wEn    = wren & hit_ram;
  assign ram_addr   = address_dmem[11:0];
  assign ram_dataIn = data;

  logic [15:0] led_reg;
  logic [31:0] cycle_reg;
  logic        chg_reg;
  rd_sel_t     rd_sel_reg;
  logic        rd_valid_reg;
  logic [31:0] rd_data_reg;
  logic [31:0] periph_rdata;

  always_comb begin
    periph_rdata = 32'h0;
    case (address_dmem)
      ADDR_LED:   periph_rdata = {16'h0, led_reg};
      ADDR_SW:    periph_rdata = {16'h0, sw_stable};
      ADDR_CYCLE: periph_rdata = cycle_reg;
      ADDR_SWCHG: periph_rdata = {31'h0, chg_reg};
      default:    periph_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_reg      <= '0;
      cycle_reg    <= '0;
      chg_reg      <= 1'b0;
      rd_sel_reg   <= SEL_RAM;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      if (wren && hit_led) begin
        led_reg <= data[15:0];
      end
      cycle_reg <= (wren && hit_cycle) ? 32'h0 : cycle_reg + 32'd1;
      // A debounced update in the same cycle as a clearing store keeps the flag set.
      if (upd) begin
        chg_reg <= 1'b1;
      end else if (wren && hit_swchg) begin
        chg_reg <= 1'b0;
      end
      rd_sel_reg   <= hit_ram ? SEL_RAM : SEL_PERIPH;
      rd_valid_reg <= 1'b1;
      rd_data_reg  <= periph_rdata;
    end
  end

  // Until the first post-reset edge the RAM output is stale, so force zero.
  always_comb begin
    q_dmem = 32'h0;
    if (rd_valid_reg) begin
      q_dmem = (rd_sel_reg == SEL_RAM) ? ram_dataOut : rd_data_reg;
    end
  end

  assign LED = led_reg;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a small registered-read RAM model.
module tb_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [15:0] SW;
  logic [15:0] LED;

  int checks = 0;
  int errors = 0;
  logic ram_we_seen;
  logic [11:0] ram_addr_seen;
  logic [31:0] ram_din_seen;

  mmio_bridge #(.DB_COUNT(4), .DB_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_dmem       (q_dmem),
    .ram_wEn      (ram_wEn),
    .ram_addr     (ram_addr),
    .ram_dataIn   (ram_dataIn),
    .ram_dataOut  (ram_dataOut),
    .SW           (SW),
    .LED          (LED)
  );

  always #5 clock = ~clock;

  // RAM model: 16 words, registered read, cleared while reset is low.
  logic [31:0] mem [0:15];
  always @(posedge clock) begin
    ram_dataOut <= mem[ram_addr[3:0]];
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (ram_wEn) begin
      mem[ram_addr[3:0]] <= ram_dataIn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one access at the falling edge, sample the RAM-side outputs before
  // the rising edge, and return 1 time unit after the rising edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    wren = we;
    address_dmem = a;
    data = d;
    #1;
    ram_we_seen   = ram_wEn;
    ram_addr_seen = ram_addr;
    ram_din_seen  = ram_dataIn;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_wen;
    logic [15:0] exp_led;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0, 32'h1000, 32'h0,         1'b1, 32'h0,         1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 32'h1001, 32'h0,         1'b1, 32'h0,         1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 32'h1003, 32'h0,         1'b1, 32'h0,         1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 32'h1000, 32'h0000ABCD,  1'b0, 32'h0,         1'b0, 16'hABCD};
    vecs[4]  = '{1'b0, 32'h1000, 32'h0,         1'b1, 32'h0000ABCD,  1'b0, 16'hABCD};
    vecs[5]  = '{1'b1, 32'h0005, 32'hDEADBEEF,  1'b0, 32'h0,         1'b1, 16'hABCD};
    vecs[6]  = '{1'b0, 32'h0005, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 16'hABCD};
    vecs[7]  = '{1'b1, 32'h1001, 32'h00001234,  1'b0, 32'h0,         1'b0, 16'hABCD};
    vecs[8]  = '{1'b0, 32'h1001, 32'h0,         1'b1, 32'h0,         1'b0, 16'hABCD};
    vecs[9]  = '{1'b0, 32'h2000, 32'h0,         1'b1, 32'h0,         1'b0, 16'hABCD};
    vecs[10] = '{1'b1, 32'h2000, 32'h00005555,  1'b0, 32'h0,         1'b0, 16'hABCD};
    vecs[11] = '{1'b0, 32'h0000, 32'h0,         1'b1, 32'h0,         1'b0, 16'hABCD};
    vecs[12] = '{1'b0, 32'h0005, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 16'hABCD};
    vecs[13] = '{1'b1, 32'h1000, 32'h0000FFFF,  1'b0, 32'h0,         1'b0, 16'hFFFF};
    vecs[14] = '{1'b0, 32'h1000, 32'h0,         1'b1, 32'h0000FFFF,  1'b0, 16'hFFFF};

    reset = 1'b0;
    wren = 1'b0;
    address_dmem = 32'h1002;
    data = 32'h0;
    SW = 16'h0;

    // Reset state, then cycle count since reset release.
    #1;
    check("reset_q", q_dmem, 32'h0);
    check("reset_led", {16'h0, LED}, 32'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_reset_q", q_dmem, 32'h0);
    repeat (5) @(posedge clock);
    #1;
    check("cycle_since_reset", q_dmem, 32'd4);

    // Table of single-cycle accesses.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].dat);
      $display("vec %0d we=%0d addr=%h data=%h q=%h led=%h ram_wEn=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].dat, q_dmem, LED, ram_we_seen);
      check($sformatf("vec%0d_ram_wEn", i), {31'h0, ram_we_seen}, {31'h0, vecs[i].exp_wen});
      check($sformatf("vec%0d_ram_addr", i), {20'h0, ram_addr_seen}, {20'h0, vecs[i].addr[11:0]});
      check($sformatf("vec%0d_ram_dataIn", i), ram_din_seen, vecs[i].dat);
      check($sformatf("vec%0d_led", i), {16'h0, LED}, {16'h0, vecs[i].exp_led});
      if (vecs[i].chk_q) check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
    end

    // Switch change: accepted exactly 2+4 edges after SW moves, chg one edge later.
    SW = 16'h00F0;
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 32'h1001, 32'h0);
      $display("sw_settle edge %0d q=%h", k, q_dmem);
      check($sformatf("sw_settle_e%0d", k), q_dmem, (k == 7) ? 32'h000000F0 : 32'h0);
    end
    step(1'b0, 32'h1003, 32'h0);
    $display("swchg read q=%h", q_dmem);
    check("chg_set", q_dmem, 32'h1);
    step(1'b1, 32'h1003, 32'h0);
    step(1'b0, 32'h1003, 32'h0);
    $display("swchg after clear q=%h", q_dmem);
    check("chg_cleared", q_dmem, 32'h0);

    // Three-cycle glitch on SW[0] must not be accepted.
    SW = 16'h00F1;
    for (int k = 0; k < 3; k++) step(1'b0, 32'h1001, 32'h0);
    SW = 16'h00F0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 32'h1001, 32'h0);
      $display("glitch edge %0d q=%h", k, q_dmem);
      check($sformatf("glitch_sw_e%0d", k), q_dmem, 32'h000000F0);
    end
    step(1'b0, 32'h1003, 32'h0);
    check("glitch_no_chg", q_dmem, 32'h0);

    // CYCLE clear: 0 after the store edge, then counting up.
    step(1'b1, 32'h1002, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 32'h1002, 32'h0);
      $display("cycle after clear +%0d q=%h", k, q_dmem);
      check($sformatf("cycle_clear_p%0d", k), q_dmem, 32'(k - 1));
    end

    // upd and a clearing store to SWCHG on the same edge: the set wins.
    SW = 16'h0F00;
    for (int k = 1; k <= 6; k++) step(1'b0, 32'h1001, 32'h0);
    step(1'b1, 32'h1003, 32'h0);
    step(1'b0, 32'h1003, 32'h0);
    $display("swchg set-vs-clear q=%h", q_dmem);
    check("chg_set_wins", q_dmem, 32'h1);
    step(1'b0, 32'h1001, 32'h0);
    check("sw_second_value", q_dmem, 32'h00000F00);

    // Asynchronous reset in the middle of a store.
    step(1'b1, 32'h1000, 32'h0000FFFF);
    check("led_ffff", {16'h0, LED}, 32'h0000FFFF);
    step(1'b0, 32'h0005, 32'h0);
    check("ram_readback_pre_reset", q_dmem, 32'hDEADBEEF);
    @(negedge clock);
    wren = 1'b1;
    address_dmem = 32'h1000;
    data = 32'h00001111;
    #2;
    reset = 1'b0;
    #1;
    $display("async reset q=%h led=%h", q_dmem, LED);
    check("async_led", {16'h0, LED}, 32'h0);
    check("async_q", q_dmem, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("in_reset_led", {16'h0, LED}, 32'h0);
    check("in_reset_q", q_dmem, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    wren = 1'b0;
    address_dmem = 32'h1003;
    #1;
    check("released_q", q_dmem, 32'h0);
    @(posedge clock);
    #1;
    check("chg_after_reset", q_dmem, 32'h0);
    step(1'b0, 32'h2000, 32'h0);
    $display("read 0x2000 q=%h", q_dmem);
    check("unmapped_read", q_dmem, 32'h0);
    step(1'b0, 32'h1000, 32'h0);
    check("lost_store_led", q_dmem, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
